divider_seq: RTL and testbench



---
 rtl/divider_seq.sv | 160 ++++++++++++++++
 tb/tb_divider_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Started by a falling edge on the push-button; results drive three 7-segment displays.
module divider_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       valid,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero,
  output logic [6:0] fnd_q_hi,
  output logic [6:0] fnd_q_lo,
  output logic [6:0] fnd_rem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] fnd_encoder(input logic [3:0] num);
    logic [6:0] seg;
    case (num)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  state_t      state_r, state_nx_s;
  logic [2:0]  counter_r, counter_nx_s;
  logic [4:0]  rem_r, rem_nx_s;
  logic [7:0]  quot_r, quot_nx_s;
  logic [3:0]  dvs_r, dvs_nx_s;
  logic        zero_r, zero_nx_s;
  logic        start_d1_r, start_d2_r;
  logic        start_on_s;
  logic [12:0] shift_s;
  logic [4:0]  step_s;
  logic        ge_s;
  logic        valid_nx_s;
  logic [7:0]  quotient_nx_s;
  logic [3:0]  remainder_nx_s;
  logic        div_zero_nx_s;

  assign start_on_s = (start_d1_r == 1'b0) && (start_d2_r == 1'b1);

  // Next-state, datapath step and result capture.
  always_comb begin
    state_nx_s     = state_r;
    counter_nx_s   = counter_r;
    rem_nx_s       = rem_r;
    quot_nx_s      = quot_r;
    dvs_nx_s       = dvs_r;
    zero_nx_s      = zero_r;
    valid_nx_s     = 1'b0;
    quotient_nx_s  = quotient;
    remainder_nx_s = remainder;
    div_zero_nx_s  = div_zero;
    // {rem, quot} shifted as one word; rem[4] is always 0 here since rem < dvs.
    shift_s        = {rem_r, quot_r} << 4'd1;
    step_s         = shift_s[12:8];
    ge_s           = (step_s >= {1'b0, dvs_r});

    case (state_r)
      IDLE: begin
        if (start_on_s) begin
          rem_nx_s     = 5'd0;
          quot_nx_s    = dividend;
          dvs_nx_s     = divisor;
          zero_nx_s    = (divisor == 4'd0);
          counter_nx_s = 3'd0;
          state_nx_s   = CALC;
        end else begin
          state_nx_s   = IDLE;
        end
      end
      CALC: begin
        if (ge_s) begin
          rem_nx_s  = step_s - {1'b0, dvs_r};
          quot_nx_s = shift_s[7:0] | 8'd1;
        end else begin
          rem_nx_s  = step_s;
          quot_nx_s = shift_s[7:0];
        end
        counter_nx_s = counter_r + 3'd1;
        if (counter_r == 3'd7) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = CALC;
        end
      end
      DONE: begin
        quotient_nx_s  = zero_r ? 8'hFF : quot_r;
        remainder_nx_s = zero_r ? 4'h0 : rem_r[3:0];
        div_zero_nx_s  = zero_r;
        valid_nx_s     = 1'b1;
        state_nx_s     = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d1_r <= 1'b1;
      start_d2_r <= 1'b1;
      state_r    <= IDLE;
      counter_r  <= 3'd0;
      rem_r      <= 5'd0;
      quot_r     <= 8'd0;
      dvs_r      <= 4'd0;
      zero_r     <= 1'b0;
      valid      <= 1'b0;
      quotient   <= 8'd0;
      remainder  <= 4'd0;
      div_zero   <= 1'b0;
    end else begin
      start_d1_r <= start;
      start_d2_r <= start_d1_r;
      state_r    <= state_nx_s;
      counter_r  <= counter_nx_s;
      rem_r      <= rem_nx_s;
      quot_r     <= quot_nx_s;
      dvs_r      <= dvs_nx_s;
      zero_r     <= zero_nx_s;
      valid      <= valid_nx_s;
      quotient   <= quotient_nx_s;
      remainder  <= remainder_nx_s;
      div_zero   <= div_zero_nx_s;
    end
  end

  assign fnd_q_hi = fnd_encoder(quotient[7:4]);
  assign fnd_q_lo = fnd_encoder(quotient[3:0]);
  assign fnd_rem  = fnd_encoder(remainder);

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed vector table, hand-written corner sequences and
// random operands checked against plain integer division.
module tb_divider_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       valid;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;
  logic [6:0] fnd_q_hi, fnd_q_lo, fnd_rem;

  int errors = 0;
  int checks = 0;

  // 7-segment glyphs {g,f,e,d,c,b,a} for hex digits 0..F.
  logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  vec_t vecs [8];

  divider_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .fnd_q_hi  (fnd_q_hi),
    .fnd_q_lo  (fnd_q_lo),
    .fnd_rem   (fnd_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected one");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Press, wait for valid (counting negedges from the press) and check the result.
  task automatic run_div(input string nm, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez);
    int lat;
    lat = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    start    = 1'b1;
    dividend = ~a;
    divisor  = ~b;
    chk({nm, " latency"}, lat, 32'd11);
    chk({nm, " quotient"}, {24'd0, quotient}, {24'd0, eq});
    chk({nm, " remainder"}, {28'd0, remainder}, {28'd0, er});
    chk({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
    chk({nm, " fnd_q_hi"}, {25'd0, fnd_q_hi}, {25'd0, seg_tab[eq[7:4]]});
    chk({nm, " fnd_q_lo"}, {25'd0, fnd_q_lo}, {25'd0, seg_tab[eq[3:0]]});
    chk({nm, " fnd_rem"}, {25'd0, fnd_rem}, {25'd0, seg_tab[er]});
    @(negedge clk);
    chk({nm, " valid pulse width"}, {31'd0, valid}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int nvalid;
    logic [7:0] cq;
    logic [3:0] cr;
    logic [7:0] ra;
    logic [3:0] rb;
    logic [7:0] mq;
    logic [3:0] mr;

    vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'h1C, r: 4'd4, z: 1'b0};
    vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'hFF, r: 4'd0, z: 1'b0};
    vecs[2] = '{a: 8'd255, b: 4'd15, q: 8'h11, r: 4'd0, z: 1'b0};
    vecs[3] = '{a: 8'd5,   b: 4'd9,  q: 8'h00, r: 4'd5, z: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 4'd3,  q: 8'h00, r: 4'd0, z: 1'b0};
    vecs[5] = '{a: 8'h37,  b: 4'd0,  q: 8'hFF, r: 4'd0, z: 1'b1};
    vecs[6] = '{a: 8'd20,  b: 4'd3,  q: 8'h06, r: 4'd2, z: 1'b0};
    vecs[7] = '{a: 8'd15,  b: 4'd4,  q: 8'h03, r: 4'd3, z: 1'b0};

    rst      = 1'b1;
    start    = 1'b1;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset quotient", {24'd0, quotient}, 32'd0);
    chk("reset remainder", {28'd0, remainder}, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    chk("reset fnd_q_hi", {25'd0, fnd_q_hi}, 32'h3F);
    chk("reset fnd_rem", {25'd0, fnd_rem}, 32'h3F);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Button held low 30 cycles with an extra press mid-run and operands changed.
    @(negedge clk);
    dividend = 8'd90;
    divisor  = 4'd7;
    start    = 1'b0;
    nvalid   = 0;
    cq       = 8'd0;
    cr       = 4'd0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start    = 1'b1;
        dividend = 8'd250;
        divisor  = 4'd3;
      end
      if (k == 4) start = 1'b0;
      if (valid === 1'b1) begin
        nvalid++;
        cq = quotient;
        cr = remainder;
      end
    end
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    chk("hold valid count", nvalid, 32'd1);
    chk("hold quotient", {24'd0, cq}, 32'd12);
    chk("hold remainder", {28'd0, cr}, 32'd6);

    // Reset asserted at E4 of 100/3.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    #1;
    chk("midrst valid", {31'd0, valid}, 32'd0);
    chk("midrst quotient", {24'd0, quotient}, 32'd0);
    chk("midrst remainder", {28'd0, remainder}, 32'd0);
    chk("midrst div_zero", {31'd0, div_zero}, 32'd0);
    chk("midrst fnd_q_lo", {25'd0, fnd_q_lo}, 32'h3F);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    chk("midrst no valid", nvalid, 32'd0);
    run_div("after rst 100/3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0);

    // Random operands against integer division.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(0, 15));
      if (rb == 4'd0) begin
        mq = 8'hFF;
        mr = 4'd0;
      end else begin
        mq = 8'(int'(ra) / int'(rb));
        mr = 4'(int'(ra) % int'(rb));
      end
      run_div($sformatf("rand %0d/%0d", ra, rb), ra, rb, mq, mr, (rb == 4'd0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
